// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks a wrapping register range through a combinational
// register-file read port and streams {addr, data} beats over valid/ready.
module regfile_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   next_addr;

  // Wrap explicitly so non-power-of-two register counts still work.
  assign next_addr = (cur_addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_addr_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    end_addr_d  = end_addr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_addr_d = first_addr;
          end_addr_d = last_addr;
          state_d    = StRead;
        end
      end
      StRead: begin
        out_data_d  = rf_rdata;
        out_addr_d  = cur_addr_q;
        out_last_d  = (cur_addr_q == end_addr_q);
        out_valid_d = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = StDone;
          end else begin
            cur_addr_d = next_addr;
            state_d    = StRead;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over a same-cycle handshake.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      cur_addr_d  = cur_addr_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      end_addr_q  <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      end_addr_q  <= end_addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rf_addr   = cur_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a register-file model and a beat scoreboard.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        abort;
  logic [4:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_addr];

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;
  beat_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .abort      (abort),
    .rf_addr    (rf_addr),
    .rf_rdata   (rf_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats are snapshotted from the model at the time the dump is requested.
  task automatic push_range(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] span;
    logic [4:0] a;
    int         n;
    span = l - f;
    n    = int'(span) + 1;
    for (int k = 0; k < n; k++) begin
      a = f + 5'(k);
      sb.push_back('{a: a, d: rf[a], l: (k == n - 1)});
    end
  endtask

  task automatic begin_dump(input logic [4:0] f, input logic [4:0] l);
    push_range(f, l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Compare each accepted beat against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && !abort && out_valid && out_ready) begin
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_beat observed addr=%0h expected no beat", out_addr);
      end
      if (sb.size() > 0) begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_addr", 64'(out_addr), 64'(e.a));
        chk("beat_data", 64'(out_data), 64'(e.d));
        chk("beat_last", 64'(out_last), 64'(e.l));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_addr", 64'(rf_addr), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_addr", 64'(out_addr), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_last", 64'(out_last), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    reset = 1'b0;
    tick();

    // Full 32-register dump with ready held high.
    begin_dump(5'd0, 5'd31);
    chk("full_busy", 64'(busy), 1);
    chk("full_valid_in_read", 64'(out_valid), 0);
    wait_done(200, n);
    chk("full_done_latency", 64'(n), 64);
    chk("full_sb_empty", 64'(sb.size()), 0);
    tick();
    chk("full_idle_busy", 64'(busy), 0);
    chk("full_done_pulse", 64'(done), 0);

    // Wrapping range 30..1, started in the first idle cycle.
    begin_dump(5'd30, 5'd1);
    wait_done(100, n);
    chk("wrap_done_latency", 64'(n), 8);
    chk("wrap_sb_empty", 64'(sb.size()), 0);
    tick();

    // Back-pressure on a single beat.
    rf[5] = 32'hDEADBEEF;
    out_ready = 1'b0;
    begin_dump(5'd5, 5'd5);
    tick();
    for (int c = 0; c < 7; c++) begin
      chk("bp_valid", 64'(out_valid), 1);
      chk("bp_addr", 64'(out_addr), 5);
      chk("bp_data", 64'(out_data), 64'h DEADBEEF);
      chk("bp_last", 64'(out_last), 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_done", 64'(done), 1);
    chk("bp_valid_after", 64'(out_valid), 0);
    chk("bp_sb_empty", 64'(sb.size()), 0);
    tick();
    chk("bp_idle", 64'(busy), 0);

    // Core write to x3 on the READ edge must not leak into the beat.
    begin_dump(5'd3, 5'd3);
    @(posedge clk);
    rf[3] <= 32'hCAFE0000;
    #1;
    chk("snap_old_data", 64'(out_data), 64'h33);
    wait_done(20, n);
    chk("snap_done_latency", 64'(n), 1);
    tick();
    begin_dump(5'd3, 5'd3);
    wait_done(20, n);
    chk("snap_new_done_latency", 64'(n), 2);
    chk("snap_sb_empty", 64'(sb.size()), 0);
    tick();

    // Start while busy is ignored; abort in SEND beats a same-cycle handshake.
    begin_dump(5'd0, 5'd7);
    first_addr = 5'd20; last_addr = 5'd25; start = 1'b1;
    tick();
    chk("ign_start_addr0", 64'(out_addr), 0);
    tick();
    start = 1'b0;
    tick();
    chk("ign_start_addr1", 64'(out_addr), 1);
    chk("abort_pre_valid", 64'(out_valid), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_valid", 64'(out_valid), 0);
    chk("abort_last", 64'(out_last), 0);
    chk("abort_sb_left", 64'(sb.size()), 7);
    sb.delete();
    for (int c = 0; c < 5; c++) begin
      chk("abort_no_done", 64'(done), 0);
      chk("abort_no_valid", 64'(out_valid), 0);
      tick();
    end

    // Asynchronous reset while a beat is pending.
    out_ready = 1'b0;
    begin_dump(5'd10, 5'd12);
    tick();
    chk("rmid_pre_valid", 64'(out_valid), 1);
    reset = 1'b1;
    #1;
    chk("rmid_valid", 64'(out_valid), 0);
    chk("rmid_addr", 64'(out_addr), 0);
    chk("rmid_data", 64'(out_data), 0);
    chk("rmid_rf_addr", 64'(rf_addr), 0);
    chk("rmid_busy", 64'(busy), 0);
    chk("rmid_done", 64'(done), 0);
    #1;
    reset = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    tick();
    chk("rmid_after_done", 64'(done), 0);
    chk("rmid_after_busy", 64'(busy), 0);

    // Recovery: single-beat dump of x31.
    begin_dump(5'd31, 5'd31);
    wait_done(20, n);
    chk("recover_done_latency", 64'(n), 2);
    chk("recover_sb_empty", 64'(sb.size()), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
